// File: rtl/spi_ctrl_pkg.sv
// spi_ctrl_pkg
//   Shared definitions for the SPI controller: frame geometry, frame field
//   positions and the controller state encoding.
//   Optional feature macro used by importers: SPI_CTRL_READBACK_EN.
package spi_ctrl_pkg;

    localparam int unsigned SPI_FRAME_BITS = 16;

    // Frame layout: {rw, addr[6:0], wdata[7:0]}
    localparam int unsigned SPI_RW_BIT   = 15;
    localparam int unsigned SPI_ADDR_MSB = 14;
    localparam int unsigned SPI_ADDR_LSB = 8;
    localparam int unsigned SPI_DATA_MSB = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } spi_ctrl_state_t;

endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div
//   Half-period timer for the SPI controller. While en_i is high it emits a
//   one-cycle tick_o every CLK_DIV cycles, the first one CLK_DIV-1 cycles
//   after enabling. While en_i is low the counter is held at zero.
//   Ports:
//     clk_i  - system clock
//     rst_i  - synchronous reset, active-high
//     en_i   - count enable
//     tick_o - half-period tick (combinational from the counter and enable)
module spi_clk_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic tick_o
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d  = '0;
        tick_o = 1'b0;
        if (en_i) begin
            if (cnt_q == LAST) begin
                tick_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_ctrl_master.sv
// spi_ctrl_master
//   SPI mode-0 controller issuing one 16-bit frame {rw, addr, wdata}, MSB
//   first, per accepted start. Frame sequence IDLE-SETUP-SHIFT-HOLD-GAP, with
//   every phase timed in SCLK half-periods of CLK_DIV system clocks.
//   Ports:
//     clk, rst         - system clock, synchronous active-high reset
//     start            - frame request, sampled only in IDLE
//     rw, addr, wdata  - frame contents, latched on acceptance
//     busy, done       - in-progress flag, completion strobe
//     rdata            - last 8 CIPO bits of the most recent completed frame
//     sclk, ncs, copi  - serial outputs (all registered)
//     cipo             - serial input
//   Macro SPI_CTRL_READBACK_EN builds the CIPO capture path; without it
//   cipo is ignored and rdata is constant zero.
module spi_ctrl_master
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       sclk,
    output logic       ncs,
    output logic       copi,
    input  logic       cipo
);

    spi_ctrl_state_t state_q, state_d;
    logic            sclk_q, sclk_d;
    logic            ncs_q, ncs_d;
    logic            copi_q, copi_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [14:0]     sh_q, sh_d;      // remaining frame bits after bit 15
    logic [3:0]      bit_q, bit_d;    // bit index in SHIFT, half-period count in GAP
    logic [15:0]     frame_in;
    logic            tick;
    logic            frame_end;

    spi_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_div (
        .clk_i (clk),
        .rst_i (rst),
        .en_i  (state_q != ST_IDLE),
        .tick_o(tick)
    );

    always_comb begin
        frame_in                             = '0;
        frame_in[SPI_RW_BIT]                 = rw;
        frame_in[SPI_ADDR_MSB:SPI_ADDR_LSB]  = addr;
        frame_in[SPI_DATA_MSB:0]             = wdata;
    end

    assign frame_end = (state_q == ST_GAP) && tick && (bit_q == 4'd1);

    always_comb begin
        state_d = state_q;
        sclk_d  = sclk_q;
        ncs_d   = ncs_q;
        copi_d  = copi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sh_d    = sh_q;
        bit_d   = bit_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SETUP;
                    ncs_d   = 1'b0;
                    busy_d  = 1'b1;
                    sclk_d  = 1'b0;
                    copi_d  = frame_in[SPI_RW_BIT];
                    sh_d    = frame_in[SPI_RW_BIT-1:0];
                    bit_d   = '0;
                end
            end
            ST_SETUP: begin
                // Leaving SETUP is the first SCLK rising edge.
                if (tick) begin
                    state_d = ST_SHIFT;
                    sclk_d  = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == 4'(SPI_FRAME_BITS - 1)) begin
                            state_d = ST_HOLD;
                            bit_d   = '0;
                        end else begin
                            copi_d = sh_q[14];
                            sh_d   = {sh_q[13:0], 1'b0};
                            bit_d  = bit_q + 4'd1;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    state_d = ST_GAP;
                    ncs_d   = 1'b1;
                    copi_d  = 1'b0;
                end
            end
            ST_GAP: begin
                // Two half-periods of deselect, counted on the bit counter.
                if (tick) begin
                    if (frame_end) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sclk_q  <= 1'b0;
            ncs_q   <= 1'b1;
            copi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sh_q    <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            sclk_q  <= sclk_d;
            ncs_q   <= ncs_d;
            copi_q  <= copi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
        end
    end

    assign sclk = sclk_q;
    assign ncs  = ncs_q;
    assign copi = copi_q;
    assign busy = busy_q;
    assign done = done_q;

`ifdef SPI_CTRL_READBACK_EN
    logic [7:0] rx_q, rx_d;
    logic [7:0] rdata_q, rdata_d;
    logic       sample;

    // CIPO is captured on the edge that raises SCLK; after 16 captures the
    // shift register holds the bits from rising edges 9..16.
    assign sample = tick && ((state_q == ST_SETUP) ||
                             ((state_q == ST_SHIFT) && !sclk_q));

    always_comb begin
        rx_d    = rx_q;
        rdata_d = rdata_q;
        if (sample) begin
            rx_d = {rx_q[6:0], cipo};
        end
        if (frame_end) begin
            rdata_d = rx_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_q    <= '0;
            rdata_q <= '0;
        end else begin
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
`else
    logic unused_cipo;
    assign unused_cipo = cipo;
    assign rdata       = '0;
`endif

endmodule

// File: tb/tb_spi_ctrl_master.sv
// tb_spi_ctrl_master
//   Self-checking bench for spi_ctrl_master at CLK_DIV = 4, 2 and 1. Each
//   frame is compared cycle by cycle against waveforms computed from the
//   frame timing formulas; a peripheral model returns a 16-bit word on CIPO.
//   Honours SPI_CTRL_READBACK_EN for the expected rdata.
module tb_spi_ctrl_master;

    logic       clk;
    logic       rst;
    logic [2:0] start_r;
    logic [2:0] cipo_r;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;

    logic [2:0] busy_w, done_w, sclk_w, ncs_w, copi_w;
    logic [7:0] rdata_w [3];

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int g_ncs_rise = 0;
    int g_ncs_fall = 0;
    int g_done     = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_ctrl_master #(.CLK_DIV(4)) u_d4 (
        .clk(clk), .rst(rst), .start(start_r[0]), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy_w[0]), .done(done_w[0]), .rdata(rdata_w[0]),
        .sclk(sclk_w[0]), .ncs(ncs_w[0]), .copi(copi_w[0]), .cipo(cipo_r[0])
    );
    spi_ctrl_master #(.CLK_DIV(2)) u_d2 (
        .clk(clk), .rst(rst), .start(start_r[1]), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy_w[1]), .done(done_w[1]), .rdata(rdata_w[1]),
        .sclk(sclk_w[1]), .ncs(ncs_w[1]), .copi(copi_w[1]), .cipo(cipo_r[1])
    );
    spi_ctrl_master #(.CLK_DIV(1)) u_d1 (
        .clk(clk), .rst(rst), .start(start_r[2]), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy_w[2]), .done(done_w[2]), .rdata(rdata_w[2]),
        .sclk(sclk_w[2]), .ncs(ncs_w[2]), .copi(copi_w[2]), .cipo(cipo_r[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected waveforms, cycle c counted from the cycle start is accepted.
    function automatic logic exp_ncs(input int c, input int d);
        return !(c >= 1 && c <= 33 * d);
    endfunction

    function automatic logic exp_busy(input int c, input int d);
        return (c >= 1 && c <= 35 * d);
    endfunction

    function automatic logic exp_done(input int c, input int d);
        return (c == 1 + 35 * d);
    endfunction

    function automatic logic exp_sclk(input int c, input int d);
        if (c >= 1 + d && c < 1 + 32 * d) return (((c - 1 - d) / d) % 2) == 0;
        return 1'b0;
    endfunction

    function automatic logic exp_copi(input int c, input int d, input logic [15:0] f);
        int idx;
        if (c < 1 || c > 33 * d) return 1'b0;
        idx = (c - 1) / (2 * d);
        if (idx > 15) idx = 15;
        return f[15 - idx];
    endfunction

    // Runs one frame on DUT k (CLK_DIV = d). Entered and left #1 after a
    // clock edge. keep_start leaves start high for a back-to-back frame;
    // stray pulses start at cycles 20 and 60; rst_at > 0 aborts the frame.
    task automatic run_frame(input int k, input int d, input logic f_rw,
                             input logic [6:0] f_addr, input logic [7:0] f_wdata,
                             input logic [15:0] resp, input bit keep_start,
                             input bit stray, input int rst_at);
        logic [15:0] frame;
        logic [15:0] got;
        logic [7:0]  exp_rd;
        logic        prev_sclk, prev_ncs;
        int last, rises, falls, bad;
        int m_ncs, m_sclk, m_copi, m_busy, m_done;
        frame = {f_rw, f_addr, f_wdata};
        rw = f_rw; addr = f_addr; wdata = f_wdata;
        start_r[k] = 1'b1;
        cipo_r[k]  = resp[15];
        last = (rst_at > 0) ? rst_at : 1 + 35 * d;
        prev_sclk = 1'b0; prev_ncs = 1'b1;
        rises = 0; falls = 0; got = '0;
        m_ncs = 0; m_sclk = 0; m_copi = 0; m_busy = 0; m_done = 0;
`ifdef SPI_CTRL_READBACK_EN
        exp_rd = resp[7:0];
`else
        exp_rd = 8'h00;
`endif
        for (int c = 1; c <= last; c++) begin
            @(posedge clk); #1;
            if (c == 1 && !keep_start) start_r[k] = 1'b0;
            if (stray && (c == 20 || c == 60)) start_r[k] = 1'b1;
            if (stray && (c == 21 || c == 61)) start_r[k] = 1'b0;
            // Inputs wander after acceptance; the latched frame must not.
            rw = 1'($urandom & 1); addr = 7'($urandom); wdata = 8'($urandom);
            if (ncs_w[k]  !== exp_ncs(c, d))         m_ncs++;
            if (sclk_w[k] !== exp_sclk(c, d))        m_sclk++;
            if (copi_w[k] !== exp_copi(c, d, frame)) m_copi++;
            if (busy_w[k] !== exp_busy(c, d))        m_busy++;
            if (done_w[k] !== exp_done(c, d))        m_done++;
            if (!prev_sclk && sclk_w[k] === 1'b1) begin
                if (rises < 16) got[15 - rises] = copi_w[k];
                rises++;
            end
            if (prev_sclk && sclk_w[k] === 1'b0) falls++;
            if (prev_ncs && ncs_w[k] === 1'b0) g_ncs_fall = cyc;
            if (!prev_ncs && ncs_w[k] === 1'b1) g_ncs_rise = cyc;
            if (done_w[k] === 1'b1) g_done = cyc;
            prev_sclk = sclk_w[k];
            prev_ncs  = ncs_w[k];
            cipo_r[k] = resp[15 - ((falls > 15) ? 15 : falls)];
            if (c == last && rst_at == 0)
                check($sformatf("D%0d rdata at done", d), 32'(rdata_w[k]), 32'(exp_rd));
        end
        check($sformatf("D%0d ncs waveform mismatches", d),  m_ncs,  0);
        check($sformatf("D%0d sclk waveform mismatches", d), m_sclk, 0);
        check($sformatf("D%0d copi waveform mismatches", d), m_copi, 0);
        check($sformatf("D%0d busy waveform mismatches", d), m_busy, 0);
        if (rst_at > 0) begin
            rst = 1'b1;
            start_r[k] = 1'b0;
            @(posedge clk); #1;
            check($sformatf("D%0d outputs after abort", d),
                  32'({sclk_w[k], ncs_w[k], copi_w[k], busy_w[k], done_w[k], rdata_w[k]}),
                  32'({5'b01000, 8'h00}));
            rst = 1'b0;
            bad = 0;
            for (int c = 0; c < 40 * d; c++) begin
                @(posedge clk); #1;
                if (done_w[k] !== 1'b0 || ncs_w[k] !== 1'b1 || busy_w[k] !== 1'b0) bad++;
            end
            check($sformatf("D%0d no activity after abort", d), bad, 0);
            return;
        end
        check($sformatf("D%0d done waveform mismatches", d), m_done, 0);
        check($sformatf("D%0d sclk rising edges", d), rises, 16);
        check($sformatf("D%0d copi bits at rising edges", d), 32'(got), 32'(frame));
        if (!keep_start) begin
            bad = 0;
            for (int c = 0; c < 2 * d + 4; c++) begin
                @(posedge clk); #1;
                if (ncs_w[k] !== 1'b1 || busy_w[k] !== 1'b0 ||
                    done_w[k] !== 1'b0 || sclk_w[k] !== 1'b0) bad++;
            end
            check($sformatf("D%0d idle after frame", d), bad, 0);
        end
    endtask

    initial begin
        int r1, dn1;
        rst = 1'b1; start_r = '0; cipo_r = '0;
        rw = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++)
            check($sformatf("reset state dut%0d", k),
                  32'({sclk_w[k], ncs_w[k], copi_w[k], busy_w[k], done_w[k], rdata_w[k]}),
                  32'({5'b01000, 8'h00}));
        rst = 1'b0;
        @(posedge clk); #1;

        // D=4 write 0x00/0xA5 with stray start pulses at cycles 20 and 60
        run_frame(0, 4, 1'b1, 7'h00, 8'hA5, 16'h0000, 1'b0, 1'b1, 0);
        // D=4 read of 0x04, peripheral returns 0x3C in the data byte
        run_frame(0, 4, 1'b0, 7'h04, 8'h00, 16'h5A3C, 1'b0, 1'b0, 0);
        for (int i = 0; i < 4; i++)
            run_frame(0, 4, 1'($urandom & 1), 7'($urandom), 8'($urandom),
                      16'($urandom), 1'b0, 1'b0, 0);
        // D=4 abort at cycle 50 in SHIFT, then a clean frame
        run_frame(0, 4, 1'b1, 7'h15, 8'h3C, 16'hFFFF, 1'b0, 1'b0, 50);
        run_frame(0, 4, 1'b1, 7'h15, 8'h3C, 16'h1234, 1'b0, 1'b0, 0);

        // D=2 back-to-back with start held
        run_frame(1, 2, 1'b1, 7'h2A, 8'h55, 16'($urandom), 1'b1, 1'b0, 0);
        r1  = g_ncs_rise;
        dn1 = g_done;
        run_frame(1, 2, 1'b1, 7'h11, 8'hC3, 16'($urandom), 1'b0, 1'b0, 0);
        check("D2 ncs high gap between frames", g_ncs_fall - r1, 5);
        check("D2 done spacing", g_done - dn1, 71);
        for (int i = 0; i < 2; i++)
            run_frame(1, 2, 1'($urandom & 1), 7'($urandom), 8'($urandom),
                      16'($urandom), 1'b0, 1'b0, 0);

        // D=1 all-ones write, then random frames
        run_frame(2, 1, 1'b1, 7'h7F, 8'hFF, 16'($urandom), 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++)
            run_frame(2, 1, 1'($urandom & 1), 7'($urandom), 8'($urandom),
                      16'($urandom), 1'b0, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spi_ctrl_master.md
# spi_ctrl_master

SPI controller (initiator) that issues 16-bit register-write and register-read frames to the onboarding SPI peripheral over SCLK/nCS/COPI/CIPO. Lives in the bench-side and chip-to-chip path as the driving end of the peripheral's serial register interface, replacing hand-written pin wiggling. Mode 0, MSB first, one frame per `start` pulse, with a `done` strobe on completion.

## Interface
- `CLK_DIV`, default 4: SCLK half-period in `clk` cycles; legal range 1..255.
- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  synchronous reset, active-high.
- `start`  input  1  request a frame; sampled only in IDLE.
- `rw`  input  1  frame bit 15; 1 = write, 0 = read.
- `addr`  input  7  register address, frame bits 14:8.
- `wdata`  input  8  write data, frame bits 7:0.
- `busy`  output  1  high from the cycle after `start` is accepted until `done`.
- `done`  output  1  one-cycle pulse at frame completion.
- `rdata`  output  8  last 8 CIPO bits of the most recent completed frame.
- `sclk`  output  1  serial clock, idle low.
- `ncs`  output  1  chip select, active-low.
- `copi`  output  1  controller-out data.
- `cipo`  input  1  controller-in data.

## Operation
- Reset values: `sclk`=0, `ncs`=1, `copi`=0, `busy`=0, `done`=0, `rdata`=0x00.
- Frame = {rw, addr[6:0], wdata[7:0]}, latched on acceptance; later input changes have no effect.
- States: IDLE → SETUP → SHIFT → HOLD → GAP → IDLE.
- IDLE: `start`=1 latches the frame and moves to SETUP.
- SETUP: `ncs`=0, `copi`=bit 15; lasts CLK_DIV cycles.
- SHIFT: 16 SCLK periods; `sclk` rises after each low half-period and falls after each high half-period. `cipo` is sampled on the cycle `sclk` goes high. `copi` advances to the next bit on each falling edge except the last.
- HOLD: `sclk`=0 for CLK_DIV cycles, then `ncs`=1 and `copi`=0.
- GAP: `ncs` stays high for 2·CLK_DIV cycles. On exit, `done`=1 for one cycle, `busy`=0, and `rdata` is updated. Return to IDLE.
- `start` outside IDLE is ignored and not queued. `start` held high starts a new frame on the first IDLE cycle after `done`.
- A bit counter (0..15) and a half-period counter (0..CLK_DIV-1) wrap cleanly. No state other than IDLE is re-entered early.
- `rst` in any state aborts the frame. On the next edge all outputs return to reset values and no `done` is produced.

## Timing
- Let D = CLK_DIV and cycle 0 = the cycle `start` is sampled in IDLE.
- Cycle 1: `ncs`=0, `busy`=1, `copi`=bit 15.
- Rising edge k (k = 1..16) at cycle 1+(2k−1)D; falling edge k at cycle 1+2kD.
- `ncs` rises at cycle 1+33D; `done` pulses at cycle 1+35D.
- Total frame: 35D+1 cycles. Minimum `ncs`-high time between back-to-back frames: 2D+1 cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `SPI_CTRL_READBACK_EN` defined: the CIPO shift register is built; `rdata` = the CIPO bits sampled on rising edges 9..16, MSB first, loaded when `done` pulses.
- Not defined: no CIPO sampling logic; `cipo` is unused; `rdata` is constant 0x00.

## Structure
- Package `spi_ctrl_pkg` holds:
  - state enum `spi_ctrl_state_t`
  - `SPI_FRAME_BITS` = 16
  - field position constants `SPI_RW_BIT`=15, `SPI_ADDR_MSB`=14, `SPI_ADDR_LSB`=8, `SPI_DATA_MSB`=7
- Sub-module `spi_clk_div`: half-period counter that emits a one-cycle `tick` every CLK_DIV cycles while enabled, and clears when disabled. The FSM advances only on `tick`.

## Test plan
- D=4, write, addr 0x00, wdata 0xA5 → `ncs` low cycles 1..132; COPI bits sampled on rising edges = 1,0000000,10100101; `done` at cycle 141; exactly 16 `sclk` rising edges.
- `start` pulsed at cycles 20 and 60 during the first frame → both ignored; only one frame; `busy` stays high continuously through cycle 140.
- `rst` asserted at cycle 50 mid-SHIFT → cycle 51: `ncs`=1, `sclk`=0, `busy`=0; no `done`; a next `start` produces a full correct frame.
- `start` held high, D=2, two writes → second `ncs` fall exactly 2D+1 = 5 cycles after the first `ncs` rise; two `done` pulses 71 cycles apart.
- With `SPI_CTRL_READBACK_EN`, read, addr 0x04, peripheral model returns 0x3C on CIPO bits 7:0 → `rdata`=0x3C when `done` pulses. Without the macro → `rdata`=0x00.
- D=1 edge case, write, addr 0x7F, wdata 0xFF → `sclk` toggles every cycle; frame bits all 1; `done` at cycle 36.
